// File: rtl/ddr_cmd_pin_sequencer.sv
// DDR4 command/address pin sequencer.
// Abstract commands are queued in a small FIFO. The head is encoded onto the
// CA pins once the command-gap and CAS-to-CAS down-counters have reached zero.
// Every cycle with no issue drives deselect (DES).
module ddr_cmd_pin_sequencer #(
   parameter int ROW_WIDTH   = 14,
   parameter int COL_WIDTH   = 10,
   parameter int BG_WIDTH    = 2,
   parameter int BA_WIDTH    = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int MIN_CMD_GAP = 1,
   parameter int TCCD        = 4,
   parameter int PAR_EN      = 1
) (
   input  logic                 clock_n,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [BG_WIDTH-1:0]  cmd_bg,
   input  logic [BA_WIDTH-1:0]  cmd_ba,
   input  logic [ROW_WIDTH-1:0] cmd_row,
   input  logic [COL_WIDTH-1:0] cmd_col,
   input  logic                 cmd_ap,
   input  logic                 cmd_bc_n,
   output logic                 cs_n,
   output logic                 act_n,
   output logic                 ras_n_a16,
   output logic                 cas_n_a15,
   output logic                 we_n_a14,
   output logic                 addr17,
   output logic                 addr13,
   output logic                 bc_n_a12,
   output logic                 addr11,
   output logic                 ap_a10,
   output logic [9:0]           addr9_0,
   output logic [BG_WIDTH-1:0]  bg_addr,
   output logic [BA_WIDTH-1:0]  ba_addr,
   output logic                 par,
   output logic                 issued_valid,
   output logic [2:0]           issued_op,
   output logic                 op_err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int GAP_W = $clog2(MIN_CMD_GAP + 1);
   localparam int CAS_W = $clog2(TCCD + 1);

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ACT = 3'd1;
   localparam logic [2:0] OP_RD  = 3'd2;
   localparam logic [2:0] OP_WR  = 3'd3;
   localparam logic [2:0] OP_PRE = 3'd4;
   localparam logic [2:0] OP_REF = 3'd5;
   localparam logic [2:0] OP_MRS = 3'd6;
   localparam logic [2:0] OP_RSV = 3'd7;

   typedef struct packed {
      logic [2:0]           op;
      logic [BG_WIDTH-1:0]  bg;
      logic [BA_WIDTH-1:0]  ba;
      logic [ROW_WIDTH-1:0] row;
      logic [COL_WIDTH-1:0] col;
      logic                 ap;
      logic                 bc_n;
   } entry_t;

   entry_t               mem_q [FIFO_DEPTH];
   entry_t               mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [CAS_W-1:0]     cas_cnt_q, cas_cnt_d;

   logic                 cs_n_q, cs_n_d;
   logic                 act_n_q, act_n_d;
   logic [17:0]          addr_q, addr_d;
   logic [BG_WIDTH-1:0]  bg_q, bg_d;
   logic [BA_WIDTH-1:0]  ba_q, ba_d;
   logic                 par_q, par_d;
   logic                 issued_valid_q, issued_valid_d;
   logic [2:0]           issued_op_q, issued_op_d;
   logic                 op_err_q, op_err_d;

   entry_t               in_entry;
   entry_t               head;
   logic                 xfer;
   logic                 push;
   logic                 fifo_empty;
   logic                 head_avail;
   logic                 head_is_cas;
   logic                 issue;
   logic                 enc_act_n;
   logic [17:0]          enc_addr;

   // Handshake, bypass head selection and the issue decision.
   always_comb begin
      cmd_ready   = !reset && (count_q < CNT_W'(FIFO_DEPTH));
      xfer        = cmd_valid && cmd_ready;
      in_entry    = '{op: cmd_op, bg: cmd_bg, ba: cmd_ba, row: cmd_row,
                      col: cmd_col, ap: cmd_ap, bc_n: cmd_bc_n};
      push        = xfer && (cmd_op != OP_RSV);
      fifo_empty  = (count_q == '0);
      // An empty queue lets a command being pushed this edge issue directly.
      head        = fifo_empty ? in_entry : mem_q[rd_ptr_q];
      head_avail  = !fifo_empty || push;
      head_is_cas = (head.op == OP_RD) || (head.op == OP_WR);
      issue       = head_avail && (gap_cnt_q == '0) &&
                    (!head_is_cas || (cas_cnt_q == '0));
   end

   // Encode the head command onto act_n and A17..A0 (A16..A14 double as ras/cas/we).
   always_comb begin
      enc_act_n = 1'b1;
      enc_addr  = '0;
      unique case (head.op)
         OP_ACT: begin
            enc_act_n = 1'b0;
            enc_addr  = 18'(head.row);
         end
         OP_RD, OP_WR: begin
            enc_addr[16]  = 1'b1;
            enc_addr[15]  = 1'b0;
            enc_addr[14]  = (head.op == OP_RD);
            enc_addr[12]  = head.bc_n;
            enc_addr[10]  = head.ap;
            enc_addr[9:0] = head.col[9:0];
         end
         OP_PRE: begin
            enc_addr[16:14] = 3'b010;
            enc_addr[10]    = head.ap;
         end
         OP_REF: begin
            enc_addr[16:14] = 3'b001;
         end
         OP_MRS: begin
            enc_addr[16:14] = 3'b000;
            enc_addr[13:0]  = head.row[13:0];
         end
         default: begin
            // NOP; reserved ops never reach the queue.
            enc_addr[16:14] = 3'b111;
         end
      endcase
   end

   // Next-state for queue, spacing counters and the pin register.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (issue) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, issue})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - GAP_W'(1) : gap_cnt_q;
      cas_cnt_d = (cas_cnt_q != '0) ? cas_cnt_q - CAS_W'(1) : cas_cnt_q;
      if (issue) begin
         gap_cnt_d = GAP_W'(MIN_CMD_GAP - 1);
         if (head_is_cas) begin
            cas_cnt_d = CAS_W'(TCCD - 1);
         end
      end

      cs_n_d         = 1'b1;
      act_n_d        = 1'b1;
      addr_d         = '1;
      bg_d           = '1;
      ba_d           = '1;
      par_d          = 1'b0;
      issued_valid_d = 1'b0;
      issued_op_d    = 3'd0;
      if (issue) begin
         cs_n_d         = 1'b0;
         act_n_d        = enc_act_n;
         addr_d         = enc_addr;
         bg_d           = head.bg;
         ba_d           = head.ba;
         par_d          = (PAR_EN != 0) ? ^{enc_act_n, enc_addr, head.bg, head.ba} : 1'b0;
         issued_valid_d = 1'b1;
         issued_op_d    = head.op;
      end

      op_err_d = xfer && (cmd_op == OP_RSV);
   end

   // Queue storage; contents need no reset because count gates every read.
   always_ff @(posedge clock_n) begin
      mem_q <= mem_d;
   end

   // Control state and pin register; reset flushes the queue and drives DES.
   always_ff @(posedge clock_n) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         gap_cnt_q      <= '0;
         cas_cnt_q      <= '0;
         cs_n_q         <= 1'b1;
         act_n_q        <= 1'b1;
         addr_q         <= '1;
         bg_q           <= '1;
         ba_q           <= '1;
         par_q          <= 1'b0;
         issued_valid_q <= 1'b0;
         issued_op_q    <= 3'd0;
         op_err_q       <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         gap_cnt_q      <= gap_cnt_d;
         cas_cnt_q      <= cas_cnt_d;
         cs_n_q         <= cs_n_d;
         act_n_q        <= act_n_d;
         addr_q         <= addr_d;
         bg_q           <= bg_d;
         ba_q           <= ba_d;
         par_q          <= par_d;
         issued_valid_q <= issued_valid_d;
         issued_op_q    <= issued_op_d;
         op_err_q       <= op_err_d;
      end
   end

   assign cs_n         = cs_n_q;
   assign act_n        = act_n_q;
   assign ras_n_a16    = addr_q[16];
   assign cas_n_a15    = addr_q[15];
   assign we_n_a14     = addr_q[14];
   assign addr17       = addr_q[17];
   assign addr13       = addr_q[13];
   assign bc_n_a12     = addr_q[12];
   assign addr11       = addr_q[11];
   assign ap_a10       = addr_q[10];
   assign addr9_0      = addr_q[9:0];
   assign bg_addr      = bg_q;
   assign ba_addr      = ba_q;
   assign par          = par_q;
   assign issued_valid = issued_valid_q;
   assign issued_op    = issued_op_q;
   assign op_err       = op_err_q;

endmodule

// File: tb/tb_ddr_cmd_pin_sequencer.sv
// Directed bench for ddr_cmd_pin_sequencer with an issue-order scoreboard.
module tb_ddr_cmd_pin_sequencer;

   localparam int ROW_W = 14;
   localparam int COL_W = 10;

   logic             clock_n = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [1:0]       cmd_bg;
   logic [1:0]       cmd_ba;
   logic [ROW_W-1:0] cmd_row;
   logic [COL_W-1:0] cmd_col;
   logic             cmd_ap;
   logic             cmd_bc_n;
   logic             cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
   logic             addr17, addr13, bc_n_a12, addr11, ap_a10;
   logic [9:0]       addr9_0;
   logic [1:0]       bg_addr, ba_addr;
   logic             par;
   logic             issued_valid;
   logic [2:0]       issued_op;
   logic             op_err;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [13:0] row;
      logic [9:0]  col;
      logic        ap;
      logic        bc_n;
   } cmd_t;

   cmd_t  exp_q[$];
   int    issue_log[$];
   int    n_total = 0;
   int    n_pass = 0;
   int    cyc = 0;
   logic  op_err_exp = 1'b0;
   logic  saw_not_ready = 1'b0;
   logic  ready_at_rd_issue = 1'b0;

   localparam logic [24:0] DES_PINS = {1'b1, 23'h7FFFFF, 1'b0};

   ddr_cmd_pin_sequencer #(
      .ROW_WIDTH(14), .COL_WIDTH(10), .BG_WIDTH(2), .BA_WIDTH(2),
      .FIFO_DEPTH(4), .MIN_CMD_GAP(1), .TCCD(4), .PAR_EN(1)
   ) dut (
      .clock_n(clock_n), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
      .cmd_ap(cmd_ap), .cmd_bc_n(cmd_bc_n),
      .cs_n(cs_n), .act_n(act_n), .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15),
      .we_n_a14(we_n_a14), .addr17(addr17), .addr13(addr13), .bc_n_a12(bc_n_a12),
      .addr11(addr11), .ap_a10(ap_a10), .addr9_0(addr9_0),
      .bg_addr(bg_addr), .ba_addr(ba_addr), .par(par),
      .issued_valid(issued_valid), .issued_op(issued_op), .op_err(op_err)
   );

   always #5 clock_n = ~clock_n;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // Expected {cs_n, act_n, ras, cas, we, A17, A13, A12, A11, A10, A9..A0, bg, ba, par}.
   function automatic logic [24:0] exp_pins(input cmd_t c);
      logic       a_n, ras, cas, we, a17, a13, a12, a11, a10;
      logic [9:0] a9;
      logic [22:0] v;
      a_n = 1'b1; ras = 1'b0; cas = 1'b0; we = 1'b0;
      a17 = 1'b0; a13 = 1'b0; a12 = 1'b0; a11 = 1'b0; a10 = 1'b0; a9 = 10'd0;
      case (c.op)
         3'd0: begin ras = 1'b1; cas = 1'b1; we = 1'b1; end
         3'd1: begin
            a_n = 1'b0;
            a13 = c.row[13]; a12 = c.row[12]; a11 = c.row[11]; a10 = c.row[10];
            a9  = c.row[9:0];
         end
         3'd2, 3'd3: begin
            ras = 1'b1; cas = 1'b0; we = (c.op == 3'd2);
            a9 = c.col; a10 = c.ap; a12 = c.bc_n;
         end
         3'd4: begin ras = 1'b0; cas = 1'b1; we = 1'b0; a10 = c.ap; end
         3'd5: begin ras = 1'b0; cas = 1'b0; we = 1'b1; end
         default: begin
            a13 = c.row[13]; a12 = c.row[12]; a11 = c.row[11]; a10 = c.row[10];
            a9  = c.row[9:0];
         end
      endcase
      v = {a_n, ras, cas, we, a17, a13, a12, a11, a10, a9, c.bg, c.ba};
      return {1'b0, v, 1'(($countones(v)) % 2)};
   endfunction

   // Advance one cycle and score whatever the pins carry.
   task automatic step();
      cmd_t e;
      logic [24:0] obs;
      @(posedge clock_n);
      #1;
      cyc++;
      if (cmd_ready !== 1'b1) saw_not_ready = 1'b1;
      obs = {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, addr17, addr13, bc_n_a12,
             addr11, ap_a10, addr9_0, bg_addr, ba_addr, par};
      if (issued_valid === 1'b1) begin
         issue_log.push_back(cyc);
         check("issue_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("issue_pins", 64'(obs), 64'(exp_pins(e)));
            check("issue_op", 64'(issued_op), 64'(e.op));
            if (issued_op == 3'd2) ready_at_rd_issue = cmd_ready;
         end
      end else begin
         check("idle_des", 64'(obs), 64'(DES_PINS));
      end
      check("op_err", 64'(op_err), 64'(op_err_exp));
      op_err_exp = 1'b0;
   endtask

   task automatic push_cmd(input logic [2:0] op, input logic [1:0] bg, input logic [1:0] ba,
                           input logic [13:0] row, input logic [9:0] col,
                           input logic ap, input logic bc_n);
      cmd_t c;
      int   n;
      c = '{op: op, bg: bg, ba: ba, row: row, col: col, ap: ap, bc_n: bc_n};
      cmd_op = op; cmd_bg = bg; cmd_ba = ba; cmd_row = row; cmd_col = col;
      cmd_ap = ap; cmd_bc_n = bc_n;
      cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("accept_timeout", 64'(cmd_ready), 64'd1);
      if (op != 3'd7) exp_q.push_back(c);
      else op_err_exp = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_bg = 2'd0; cmd_ba = 2'd0;
      cmd_row = '0; cmd_col = '0; cmd_ap = 1'b0; cmd_bc_n = 1'b1;

      // Reset held three cycles.
      repeat (3) begin
         step();
         check("rst_cs_n", 64'(cs_n), 64'd1);
         check("rst_par", 64'(par), 64'd0);
         check("rst_ready", 64'(cmd_ready), 64'd0);
         check("rst_issued_op", 64'(issued_op), 64'd0);
      end
      reset = 1'b0;
      step();
      check("ready_after_rst", 64'(cmd_ready), 64'd1);

      // Single ACT, next-cycle latency, then DES.
      push_cmd(3'd1, 2'd1, 2'd2, 14'h0155, 10'd0, 1'b0, 1'b1);
      check("act_cs_n", 64'(cs_n), 64'd0);
      check("act_act_n", 64'(act_n), 64'd0);
      check("act_addr9_0", 64'(addr9_0), 64'h155);
      check("act_par", 64'(par), 64'd1);
      check("act_issued_op", 64'(issued_op), 64'd1);
      step();
      check("act_then_des", 64'(cs_n), 64'd1);

      // RD, RD, WR back to back: tCCD spacing of 4.
      saw_not_ready = 1'b0;
      issue_log.delete();
      push_cmd(3'd2, 2'd0, 2'd1, 14'd0, 10'h3A5, 1'b1, 1'b1);
      push_cmd(3'd2, 2'd2, 2'd3, 14'd0, 10'h0F0, 1'b0, 1'b0);
      push_cmd(3'd3, 2'd1, 2'd0, 14'd0, 10'h1FF, 1'b1, 1'b1);
      drain(40);
      check("cas_issue_count", 64'(issue_log.size()), 64'd3);
      if (issue_log.size() >= 3) begin
         check("tccd_rd2", 64'(issue_log[1] - issue_log[0]), 64'd4);
         check("tccd_wr", 64'(issue_log[2] - issue_log[0]), 64'd8);
      end
      check("ready_stayed_high", 64'(saw_not_ready), 64'd0);
      repeat (4) step();

      // Fill the queue behind a tCCD-blocked RD.
      saw_not_ready = 1'b0;
      issue_log.delete();
      push_cmd(3'd2, 2'd0, 2'd0, 14'd0, 10'h011, 1'b0, 1'b1);
      push_cmd(3'd2, 2'd1, 2'd1, 14'd0, 10'h022, 1'b0, 1'b1);
      push_cmd(3'd2, 2'd2, 2'd2, 14'd0, 10'h033, 1'b1, 1'b1);
      push_cmd(3'd4, 2'd0, 2'd0, 14'd0, 10'd0, 1'b0, 1'b1);
      push_cmd(3'd4, 2'd1, 2'd3, 14'd0, 10'd0, 1'b1, 1'b1);
      push_cmd(3'd4, 2'd2, 2'd1, 14'd0, 10'd0, 1'b0, 1'b1);
      check("full_ready_low", 64'(cmd_ready), 64'd0);
      push_cmd(3'd4, 2'd3, 2'd2, 14'd0, 10'd0, 1'b1, 1'b1);
      drain(40);
      check("full_saw_backpressure", 64'(saw_not_ready), 64'd1);
      check("ready_after_pop", 64'(ready_at_rd_issue), 64'd1);
      check("no_loss", 64'(issue_log.size()), 64'd7);
      if (issue_log.size() >= 3)
         check("tccd_rd3", 64'(issue_log[2] - issue_log[1]), 64'd4);
      repeat (4) step();

      // Reserved op: error pulse, no pins, queue untouched.
      push_cmd(3'd7, 2'd3, 2'd3, 14'h3FFF, 10'h3FF, 1'b1, 1'b1);
      step();
      push_cmd(3'd1, 2'd3, 2'd1, 14'h2AAA, 10'd0, 1'b0, 1'b1);
      check("bypass_after_op7", 64'(issued_valid), 64'd1);
      check("act_addr13", 64'(addr13), 64'd1);

      // Remaining ops through the scoreboard.
      push_cmd(3'd6, 2'd0, 2'd1, 14'h1234, 10'd0, 1'b0, 1'b1);
      push_cmd(3'd5, 2'd2, 2'd0, 14'd0, 10'd0, 1'b0, 1'b1);
      push_cmd(3'd0, 2'd1, 2'd1, 14'd0, 10'd0, 1'b0, 1'b1);
      push_cmd(3'd4, 2'd0, 2'd2, 14'd0, 10'd0, 1'b1, 1'b1);
      drain(20);
      repeat (4) step();

      // Reset with three commands queued flushes them.
      push_cmd(3'd2, 2'd0, 2'd0, 14'd0, 10'h001, 1'b0, 1'b1);
      push_cmd(3'd2, 2'd1, 2'd0, 14'd0, 10'h002, 1'b0, 1'b1);
      push_cmd(3'd2, 2'd2, 2'd0, 14'd0, 10'h003, 1'b0, 1'b1);
      push_cmd(3'd3, 2'd3, 2'd0, 14'd0, 10'h004, 1'b0, 1'b1);
      reset = 1'b1;
      exp_q.delete();
      step();
      check("flush_cs_n", 64'(cs_n), 64'd1);
      check("flush_issued", 64'(issued_valid), 64'd0);
      check("flush_ready", 64'(cmd_ready), 64'd0);
      reset = 1'b0;
      issue_log.delete();
      repeat (10) step();
      check("no_issue_after_flush", 64'(issue_log.size()), 64'd0);
      check("ready_after_flush", 64'(cmd_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ddr_cmd_pin_sequencer.md
Name: ddr_cmd_pin_sequencer

Overview:
Parametrised DDR4 command/address pin driver that replaces per-call pin tasks with a clocked, queued sequencer. It accepts abstract commands over a valid/ready handshake into a FIFO and encodes each command onto the DDR4 CA pins per the JEDEC truth table. It enforces minimum command spacing and CAS-to-CAS spacing (tCCD), generates CA parity, and drives deselect (DES) on every idle cycle. It sits between the controller scheduler and the DDR interface pins.

Parameters:
ROW_WIDTH, 14, row address width; legal range 14..18.
COL_WIDTH, 10, column address width; fixed at 10 for DDR4 x8/x16.
BG_WIDTH, 2, bank group address width.
BA_WIDTH, 2, bank address width.
FIFO_DEPTH, 4, command queue entries; power of two, at least 2.
MIN_CMD_GAP, 1, minimum cycles between any two issued commands; at least 1.
TCCD, 4, minimum cycles between consecutive RD/WR issues; at least 1.
PAR_EN, 1, when 1 drive computed parity on par; when 0 par is held at 0.

Ports:
clock_n  in  1  command clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue can accept a command
cmd_op  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 reserved
cmd_bg  in  BG_WIDTH  bank group
cmd_ba  in  BA_WIDTH  bank
cmd_row  in  ROW_WIDTH  row address for ACT; MRS opcode in bits [13:0]
cmd_col  in  COL_WIDTH  column address for RD/WR
cmd_ap  in  1  auto-precharge for RD/WR; all-bank flag for PRE
cmd_bc_n  in  1  burst chop, active low, for RD/WR
cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14  out  1 each  command pins
addr17, addr13, bc_n_a12, addr11, ap_a10  out  1 each  address pins
addr9_0  out  10  address pins A9..A0
bg_addr  out  BG_WIDTH  bank group pins
ba_addr  out  BA_WIDTH  bank pins
par  out  1  even CA parity
issued_valid  out  1  one-cycle pulse: pins carry a command this cycle
issued_op  out  3  op code of the command on the pins
op_err  out  1  one-cycle pulse: reserved op 7 was accepted and discarded

Behaviour:
- Reset is synchronous and active-high. It flushes the FIFO and clears both spacing counters.
- During reset and in the first cycle after it: all pins at DES (cs_n=1, every other CA pin 1, par=0); issued_valid=0, issued_op=0, op_err=0. cmd_ready=0 during reset and 1 from the first cycle after it.
- Handshake: a command transfers on an edge where cmd_valid and cmd_ready are both 1.
- cmd_ready = (count < FIFO_DEPTH). It depends on registered count only; there is no combinational pop-to-ready path. A push and pop in the same cycle keep count unchanged.
- Op 7: the transfer completes but the op is not queued. op_err pulses for 1 cycle, in the cycle after the edge.
- Issue condition at an edge: FIFO not empty (or a bypass push this edge into an empty FIFO), gap_cnt==0, and, if the head op is RD/WR, cas_cnt==0.
  - On issue: pins register loads the encoded head, the head pops, and gap_cnt loads MIN_CMD_GAP-1.
  - RD/WR issue also loads cas_cnt with TCCD-1.
  - Both counters decrement to 0 and saturate there.
- Latency: a command accepted into an empty FIFO with counters at 0 appears on the pins in the cycle following the handshake edge.
- Each issued command occupies the pins for exactly 1 cycle. Any cycle with no issue drives DES.
- Encoding. Every listed pin not stated below is 0 while cs_n=0.
  - NOP: act_n=1; ras_n_a16, cas_n_a15 and we_n_a14 all 1.
  - ACT: act_n=0. A17..A0 = cmd_row zero-extended to 18 bits, so ras_n_a16, cas_n_a15 and we_n_a14 carry row bits 16..14.
  - RD: act_n=1, ras=1, cas=0, we=1; addr9_0=cmd_col; ap_a10=cmd_ap; bc_n_a12=cmd_bc_n.
  - WR: as RD but we=0.
  - PRE: act_n=1, ras=0, cas=1, we=0; ap_a10=cmd_ap.
  - REF: act_n=1, ras=0, cas=0, we=1.
  - MRS: act_n=1, ras=0, cas=0, we=0; A13..A0 = cmd_row[13:0].
  - bg_addr and ba_addr carry cmd_bg and cmd_ba for all ops.
- Parity: when PAR_EN=1 and cs_n=0, par is chosen so that the total count of ones is even across act_n, ras, cas, we, bg_addr, ba_addr, A17, A13, A12, A11, A10 and A9..A0. In DES, par=0.
- Ordering is strict FIFO. A blocked RD/WR at the head stalls younger commands; there is no reordering.

Test Plan:
- Reset held for 3 cycles, then released -> cs_n=1, par=0, cmd_ready=0 during reset; cmd_ready=1 in the first cycle after release; FIFO empty.
- Single ACT (bg=1, ba=2, row=0x0155, ROW_WIDTH=14) -> on the next cycle: cs_n=0, act_n=0, addr9_0=0x155, addr13=0, ras/cas/we=0, par=1, issued_op=1. DES on the following cycle.
- RD, RD, WR pushed on consecutive cycles (TCCD=4, MIN_CMD_GAP=1) -> issues at cycles t, t+4, t+8, with DES in between; cmd_ready stays 1 throughout.
- Push 4 PREs while an RD blocks on tCCD (FIFO_DEPTH=4) -> cmd_ready=0 when count reaches 4, and 1 again the cycle after the first pop; no command is lost.
- Push op 7 -> op_err pulses 1 cycle; no pin activity; count unchanged.
- Assert reset while 3 commands are queued -> FIFO flushed, pins DES on the next cycle, no further issued_valid.
